// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - parametrised universal shift register with burst engine
//
// Purpose:
//   Register with hold, shift right, shift left and parallel load, serial
//   in/out at both ends. A burst engine performs a programmed number of shifts
//   in one direction without further host action.
//
// Optional feature macro: USR_ROTATE_EN
//   Defined   -> adds input `rot`; rot=1 turns every shift into a rotate.
//   Undefined -> no `rot` port; shifts always take the serial inputs.
//
// Ports:
//   sys_clk      in   1      clock, rising edge
//   sys_rst_n    in   1      synchronous reset, active-low
//   en           in   1      step enable; 0 freezes all state
//   mode         in   2      00 hold, 01 shift right, 10 shift left, 11 load
//   d            in   WIDTH  parallel load data
//   sin_msb      in   1      bit entering q[WIDTH-1] on a right shift
//   sin_lsb      in   1      bit entering q[0] on a left shift
//   burst_start  in   1      start a burst in the mode's direction
//   burst_len    in   CNT_W  number of shifts in the burst
//   rot          in   1      (USR_ROTATE_EN only) rotate instead of shift
//   q            out  WIDTH  register contents
//   sout_msb     out  1      q[WIDTH-1]
//   sout_lsb     out  1      q[0]
//   busy         out  1      high while a burst is running
//   done         out  1      one-cycle pulse after a burst completes

module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_msb,
  input  logic             sin_lsb,
  input  logic             burst_start,
  input  logic [CNT_W-1:0] burst_len,
`ifdef USR_ROTATE_EN
  input  logic             rot,
`endif
  output logic [WIDTH-1:0] q,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  // Registered state
  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] r_rem;
  logic             r_dir;   // latched burst direction: 0 right, 1 left
  logic             r_done;

  // Next-state values
  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic [CNT_W-1:0] w_rem_nxt;
  logic             w_dir_nxt;
  logic             w_done_nxt;

  // Shift datapath
  logic             w_rot;
  logic             w_in_msb;
  logic             w_in_lsb;
  logic [WIDTH-1:0] w_shr;
  logic [WIDTH-1:0] w_shl;
  logic             w_mode_is_shift;
  logic             w_busy;

`ifdef USR_ROTATE_EN
  assign w_rot = rot;
`else
  assign w_rot = 1'b0;
`endif

  // A rotate is a shift whose incoming bit is the one falling off the far end.
  assign w_in_msb = w_rot ? r_q[0]       : sin_msb;
  assign w_in_lsb = w_rot ? r_q[WIDTH-1] : sin_lsb;

  assign w_shr = {w_in_msb, r_q[WIDTH-1:1]};
  assign w_shl = {r_q[WIDTH-2:0], w_in_lsb};

  assign w_mode_is_shift = (mode == MODE_SHR) || (mode == MODE_SHL);

  // State register
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state <= ST_IDLE;
      r_q     <= '0;
      r_rem   <= '0;
      r_dir   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_rem   <= w_rem_nxt;
      r_dir   <= w_dir_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_rem_nxt   = r_rem;
    w_dir_nxt   = r_dir;
    w_done_nxt  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (en) begin
          if (burst_start && w_mode_is_shift) begin
            // The start edge only arms the engine; the first shift is on
            // the following enabled edge.
            w_dir_nxt = (mode == MODE_SHL);
            w_rem_nxt = burst_len;
            if (burst_len != '0) begin
              w_state_nxt = ST_BURST;
            end else begin
              w_done_nxt = 1'b1;
            end
          end else begin
            case (mode)
              MODE_SHR:  w_q_nxt = w_shr;
              MODE_SHL:  w_q_nxt = w_shl;
              MODE_LOAD: w_q_nxt = d;
              MODE_HOLD: w_q_nxt = r_q;
              default:   w_q_nxt = r_q;
            endcase
          end
        end
      end

      ST_BURST: begin
        if (en) begin
          w_q_nxt   = r_dir ? w_shl : w_shr;
          w_rem_nxt = r_rem - CNT_W'(1);
          // rem can only be 0 here after a corrupted state; treat it as last.
          if (r_rem <= CNT_W'(1)) begin
            w_state_nxt = ST_IDLE;
            w_rem_nxt   = '0;
            w_done_nxt  = 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs
  always_comb begin
    w_busy = (r_state == ST_BURST);
  end

  assign q        = r_q;
  assign sout_msb = r_q[WIDTH-1];
  assign sout_lsb = r_q[0];
  assign busy     = w_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - table-driven self-checking bench for univ_shift_reg (WIDTH=8)

module tb_univ_shift_reg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             sys_clk;
  logic             sys_rst_n;
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin_msb;
  logic             sin_lsb;
  logic             burst_start;
  logic [CNT_W-1:0] burst_len;
`ifdef USR_ROTATE_EN
  logic             rot;
`endif
  logic [WIDTH-1:0] q;
  logic             sout_msb;
  logic             sout_lsb;
  logic             busy;
  logic             done;

  int n_pass;
  int n_total;

  univ_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .en          (en),
    .mode        (mode),
    .d           (d),
    .sin_msb     (sin_msb),
    .sin_lsb     (sin_lsb),
    .burst_start (burst_start),
    .burst_len   (burst_len),
`ifdef USR_ROTATE_EN
    .rot         (rot),
`endif
    .q           (q),
    .sout_msb    (sout_msb),
    .sout_lsb    (sout_lsb),
    .busy        (busy),
    .done        (done)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic [7:0] d;
    logic       smsb;
    logic       slsb;
    logic       bst;
    logic [3:0] blen;
    logic [7:0] q;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst_n, input logic e, input logic [1:0] m,
                     input logic [7:0] dd, input logic sm, input logic sl,
                     input logic b, input logic [3:0] bl,
                     input logic [7:0] eq, input logic eb, input logic ed);
    vec_t v;
    v.rst_n = rst_n; v.en = e; v.mode = m; v.d = dd; v.smsb = sm; v.slsb = sl;
    v.bst = b; v.blen = bl; v.q = eq; v.busy = eb; v.done = ed;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic drive(input logic rst_n, input logic e, input logic [1:0] m,
                       input logic [7:0] dd, input logic sm, input logic sl,
                       input logic b, input logic [3:0] bl);
    sys_rst_n = rst_n; en = e; mode = m; d = dd; sin_msb = sm; sin_lsb = sl;
    burst_start = b; burst_len = bl;
  endtask

`ifdef USR_ROTATE_EN
  localparam logic [7:0] EXP_ROT_R = 8'hC0;
  localparam logic [7:0] EXP_ROT_L = 8'h81;
`else
  localparam logic [7:0] EXP_ROT_R = 8'h40;
  localparam logic [7:0] EXP_ROT_L = 8'h80;
`endif

  initial begin
    n_pass  = 0;
    n_total = 0;
`ifdef USR_ROTATE_EN
    rot = 1'b0;
`endif
    drive(1'b0, 1'b1, 2'b11, 8'hFF, 1'b0, 1'b0, 1'b0, 4'd0);

    //   rst en mode d      sm sl bst len   q     busy done
    add(0, 1, 2'b11, 8'hFF, 0, 0, 0, 4'd0, 8'h00, 0, 0); // reset
    add(0, 1, 2'b11, 8'hFF, 0, 0, 0, 4'd0, 8'h00, 0, 0);
    add(1, 1, 2'b11, 8'hA5, 0, 0, 0, 4'd0, 8'hA5, 0, 0); // load
    add(1, 1, 2'b01, 8'h00, 1, 0, 0, 4'd0, 8'hD2, 0, 0); // shr, sin_msb=1
    add(1, 1, 2'b00, 8'h00, 0, 0, 0, 4'd0, 8'hD2, 0, 0); // hold
    add(1, 1, 2'b10, 8'h00, 0, 1, 0, 4'd0, 8'hA5, 0, 0); // shl, sin_lsb=1
    add(1, 0, 2'b11, 8'h00, 0, 0, 0, 4'd0, 8'hA5, 0, 0); // en=0 freeze
    add(1, 1, 2'b11, 8'h3C, 0, 0, 1, 4'd3, 8'h3C, 0, 0); // start ignored on load
    add(1, 1, 2'b00, 8'h00, 0, 0, 1, 4'd3, 8'h3C, 0, 0); // start ignored on hold
    add(1, 1, 2'b11, 8'h81, 0, 0, 0, 4'd0, 8'h81, 0, 0); // load 81
    add(1, 1, 2'b10, 8'h00, 0, 0, 1, 4'd3, 8'h81, 1, 0); // left burst 3, no shift yet
    add(1, 1, 2'b11, 8'hFF, 0, 0, 0, 4'd0, 8'h02, 1, 0); // mode ignored
    add(1, 1, 2'b01, 8'h00, 0, 0, 1, 4'd1, 8'h04, 1, 0); // start/mode ignored
    add(1, 1, 2'b01, 8'h00, 1, 0, 0, 4'd0, 8'h08, 0, 1); // last shift, done
    add(1, 1, 2'b00, 8'h00, 0, 0, 0, 4'd0, 8'h08, 0, 0); // done drops
    add(1, 1, 2'b11, 8'h0F, 0, 0, 0, 4'd0, 8'h0F, 0, 0); // load 0F
    add(1, 1, 2'b01, 8'h00, 1, 0, 1, 4'd4, 8'h0F, 1, 0); // right burst 4
    add(1, 1, 2'b00, 8'h00, 0, 0, 0, 4'd0, 8'h07, 1, 0); // shift 1 (sin 0)
    add(1, 0, 2'b00, 8'h00, 1, 1, 0, 4'd0, 8'h07, 1, 0); // stall
    add(1, 0, 2'b00, 8'h00, 1, 1, 0, 4'd0, 8'h07, 1, 0); // stall
    add(1, 1, 2'b00, 8'h00, 1, 0, 0, 4'd0, 8'h83, 1, 0); // shift 2 (sin 1)
    add(1, 1, 2'b00, 8'h00, 1, 0, 0, 4'd0, 8'hC1, 1, 0); // shift 3 (sin 1)
    add(1, 1, 2'b00, 8'h00, 0, 0, 0, 4'd0, 8'h60, 0, 1); // shift 4, done 6 after start
    add(1, 1, 2'b00, 8'h00, 0, 0, 0, 4'd0, 8'h60, 0, 0);
    add(1, 1, 2'b10, 8'h00, 0, 1, 1, 4'd0, 8'h60, 0, 1); // zero-length burst
    add(1, 1, 2'b00, 8'h00, 0, 0, 0, 4'd0, 8'h60, 0, 0);
    add(1, 0, 2'b10, 8'h00, 0, 1, 1, 4'd3, 8'h60, 0, 0); // start with en=0 ignored
    add(1, 1, 2'b00, 8'h00, 0, 0, 0, 4'd0, 8'h60, 0, 0);
    add(1, 1, 2'b10, 8'h00, 0, 1, 1, 4'd5, 8'h60, 1, 0); // left burst 5
    add(1, 1, 2'b10, 8'h00, 0, 1, 0, 4'd0, 8'hC1, 1, 0);
    add(1, 1, 2'b10, 8'h00, 0, 1, 0, 4'd0, 8'h83, 1, 0);
    add(0, 1, 2'b10, 8'h00, 0, 1, 0, 4'd0, 8'h00, 0, 0); // reset mid-burst
    add(1, 1, 2'b00, 8'h00, 0, 0, 0, 4'd0, 8'h00, 0, 0); // no done after abort
    add(1, 1, 2'b00, 8'h00, 0, 0, 0, 4'd0, 8'h00, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_n, vecs[i].en, vecs[i].mode, vecs[i].d,
            vecs[i].smsb, vecs[i].slsb, vecs[i].bst, vecs[i].blen);
      step();
      check($sformatf("vec%0d q", i),        32'(q),        32'(vecs[i].q));
      check($sformatf("vec%0d busy", i),     32'(busy),     32'(vecs[i].busy));
      check($sformatf("vec%0d done", i),     32'(done),     32'(vecs[i].done));
      check($sformatf("vec%0d sout_msb", i), 32'(sout_msb), 32'(vecs[i].q[7]));
      check($sformatf("vec%0d sout_lsb", i), 32'(sout_lsb), 32'(vecs[i].q[0]));
    end

    // Burst longer than WIDTH: sin_msb=1 for shifts 1..8, 0 for shifts 9..10.
    drive(1'b1, 1'b1, 2'b11, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
    step();
    drive(1'b1, 1'b1, 2'b01, 8'h00, 1'b1, 1'b0, 1'b1, 4'd10);
    step();
    check("long start busy", 32'(busy), 32'd1);
    begin
      int busy_bad;
      busy_bad = 0;
      for (int k = 1; k <= 10; k++) begin
        drive(1'b1, 1'b1, 2'b00, 8'h00, (k <= 8), 1'b0, 1'b0, 4'd0);
        step();
        if (k < 10 && (busy !== 1'b1 || done !== 1'b0)) busy_bad++;
      end
      check("long busy through burst", 32'(busy_bad), 32'd0);
    end
    check("long q", 32'(q), 32'h3F);
    check("long done", 32'(done), 32'd1);
    check("long busy end", 32'(busy), 32'd0);

    // Rotate (or plain shift without the macro) with sin inputs held at 0.
    drive(1'b1, 1'b1, 2'b11, 8'h81, 1'b0, 1'b0, 1'b0, 4'd0);
    step();
`ifdef USR_ROTATE_EN
    rot = 1'b1;
`endif
    drive(1'b1, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 1'b1, 4'd1);
    step();
    check("rot start busy", 32'(busy), 32'd1);
    check("rot start q", 32'(q), 32'h81);
    drive(1'b1, 1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
    step();
    check("rot burst q", 32'(q), 32'(EXP_ROT_R));
    check("rot burst done", 32'(done), 32'd1);
    drive(1'b1, 1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
    step();
    check("rot idle left q", 32'(q), 32'(EXP_ROT_L));
    check("rot idle done", 32'(done), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
